row_bias_server: RTL and testbench
==================================

Name: row_bias_server

Overview:
- Responder side of the tile row-bias request interface.
- Holds one row's bias: an ordered permutation of the GRID_LEN 1-hot values.
- Answers a tile's 1-hot rqindex with the stored entry, one cycle later.
- On updaterowbias, reshuffles the permutation with an LFSR-driven Fisher-Yates pass so that the next brute-force sweep tries values in a new order.

Parameters:
- LEN, default `GRID_LEN (9): number of values per row; entry width and entry count.
- SEED_DEFAULT, default 16'hACE1: LFSR value after reset; also replaces any zero seed.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rqindex  in  LEN+1  1-hot entry request; bit LEN is the tile's "exhausted/home" position.
- updaterowbias  in  1  single-cycle pulse that starts a reshuffle.
- seed  in  16  LFSR seed value.
- seedload  in  1  loads seed into the LFSR; honoured only in IDLE.
- rowbias  out  LEN  1-hot value of the requested entry, registered.
- ready  out  1  high in IDLE; low while a shuffle is in progress.

Behaviour:
- Reset:
  - entry[i] = 1<<i (identity permutation).
  - rowbias = 0, ready = 1, state = IDLE, lfsr = SEED_DEFAULT, i_ptr = LEN-1.
- Read path, 1-cycle latency:
  - If rqindex at edge t has exactly one bit k < LEN set and state is IDLE, rowbias after edge t equals entry[k].
  - If rqindex[LEN] is set, rqindex is zero, rqindex is not 1-hot, or state is not IDLE, rowbias after edge t is 0.
  - This timing lets a tile that presents rqindex in its request cycle capture rowbias in the following cycle.
- LFSR:
  - 16-bit Galois LFSR, taps 16'hB400, advances every cycle, including in IDLE.
  - seedload in IDLE sets lfsr = (seed==0 ? SEED_DEFAULT : seed) and replaces that cycle's advance.
  - seedload outside IDLE is ignored.
- State machine:
  - IDLE: on updaterowbias go to SHUFFLE, set i_ptr = LEN-1, ready = 0. If updaterowbias and seedload arrive together, the seed loads first and the shuffle then starts.
  - SHUFFLE, one step per cycle:
    - Candidate j = lfsr[W-1:0], where W = clog2(i_ptr+1) taken from a constant table indexed by i_ptr.
    - If j <= i_ptr: swap entry[i_ptr] with entry[j] (j == i_ptr is a no-op swap), then decrement i_ptr.
    - If j > i_ptr: reject; no swap, retry next cycle.
    - If a swap completes with i_ptr == 1, go to DONE instead of decrementing.
  - DONE: one cycle with ready = 0, then IDLE with ready = 1.
- Entries remain a permutation at every cycle boundary; the contents are never all-zero or duplicated.
- updaterowbias while not IDLE is ignored; no queueing.
- Reset mid-shuffle restores the identity permutation and IDLE within one cycle.
- LEN = 1: SHUFFLE goes straight to DONE; no swap.

Decomposition:
- Shared package grid_pkg:
  - Typedef rowbias_fsm_state {IDLE, SHUFFLE, DONE}.
  - Constant LFSR_TAPS = 16'hB400 and SEED_DEFAULT.
  - Function clog2 for the per-i_ptr mask width.
- Sub-module lfsr16:
  - Ports clock, reset, load, loadval[15:0], state[15:0].
  - Reused later by other randomizing blocks.
- Entry array, swap datapath and read mux stay in row_bias_server.

Test Plan:
- Reset, then rqindex = 1<<k for k = 0..LEN-1 on consecutive cycles -> rowbias one cycle later equals 1<<k; rqindex = 1<<LEN -> rowbias = 0.
- Illegal rqindex 10'b0000000011 and 10'b0 -> rowbias = 0 next cycle; stored entries unchanged.
- seedload with seed 16'h1234, then updaterowbias -> ready drops next cycle and stays low until DONE. Afterwards, reading all entries yields exactly one 1-hot of each value (OR = all ones, popcount of each = 1), and the order matches the golden-model permutation for seed 16'h1234. Repeat with the same seed -> identical order.
- seedload with seed 0 -> LFSR holds 16'hACE1; the shuffle result matches the SEED_DEFAULT golden model.
- During SHUFFLE: drive rqindex = 1<<3 -> rowbias = 0. Pulse updaterowbias again -> ignored; total shuffle length and result match a single shuffle.
- Assert reset mid-SHUFFLE -> next cycle ready = 1 and entry[i] = 1<<i for all i.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared definitions for the tile grid blocks: row-bias FSM states,
// LFSR constants and a constant-foldable ceil(log2) helper.
package grid_pkg;

  localparam int GRID_LEN = 9;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    DONE    = 2'd2
  } rowbias_fsm_state;

  // Smallest r with (1 << r) >= n; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that free-runs every cycle; a load replaces the advance,
// and a zero load value is swapped for the reset value so the register never locks up.
module lfsr16
  import grid_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = SEED_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] loadval,
  output logic [15:0] state
);

  logic [15:0] state_reg;
  logic [15:0] state_next;

  always_comb begin
    state_next = state_reg[0] ? ((state_reg >> 1) ^ LFSR_TAPS) : (state_reg >> 1);
    if (load) begin
      state_next = (loadval == 16'd0) ? RESET_VAL : loadval;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RESET_VAL;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/row_bias_server.sv
// Holds one row's bias permutation, answers 1-hot entry requests with one cycle
// of latency, and reshuffles the permutation with an LFSR-driven Fisher-Yates pass.
module row_bias_server
  import grid_pkg::*;
#(
  parameter int          LEN          = GRID_LEN,
  parameter logic [15:0] SEED_DEFAULT = grid_pkg::SEED_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [LEN:0]   rqindex,
  input  logic           updaterowbias,
  input  logic [15:0]    seed,
  input  logic           seedload,
  output logic [LEN-1:0] rowbias,
  output logic           ready
);

  localparam int PTR_W = (LEN > 1) ? clog2(LEN) : 1;

  rowbias_fsm_state state_reg, state_next;
  logic [PTR_W-1:0] i_ptr_reg, i_ptr_next;
  logic [LEN-1:0]   rowbias_reg, rowbias_next;

  logic [LEN-1:0]   entry [LEN];
  logic [15:0]      mask_tbl [LEN];
  logic [15:0]      lfsr_state;
  logic             lfsr_load;

  logic [15:0]      mask_sel;
  logic [15:0]      cand;
  logic [15:0]      ptr16;
  logic             accept;
  logic             do_swap;
  logic [LEN-1:0]   ip_val;
  logic [LEN-1:0]   j_val;

  assign lfsr_load = seedload && (state_reg == IDLE);

  lfsr16 #(
    .RESET_VAL(SEED_DEFAULT)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (lfsr_load),
    .loadval(seed),
    .state  (lfsr_state)
  );

  // Candidate mask for each i_ptr: just wide enough to cover 0..i_ptr.
  for (genvar gi = 0; gi < LEN; gi++) begin : g_mask
    assign mask_tbl[gi] = 16'((1 << clog2(gi + 1)) - 1);
  end

  always_comb begin
    mask_sel = '0;
    ip_val   = '0;
    for (int k = 0; k < LEN; k++) begin
      if (PTR_W'(k) == i_ptr_reg) begin
        mask_sel = mask_tbl[k];
        ip_val   = entry[k];
      end
    end
  end

  assign cand   = lfsr_state & mask_sel;
  assign ptr16  = 16'(i_ptr_reg);
  assign accept = (cand <= ptr16);

  always_comb begin
    j_val = '0;
    for (int k = 0; k < LEN; k++) begin
      if (16'(k) == cand) begin
        j_val = entry[k];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    i_ptr_next = i_ptr_reg;
    do_swap    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (updaterowbias) begin
          state_next = SHUFFLE;
          i_ptr_next = PTR_W'(LEN - 1);
        end
      end
      SHUFFLE: begin
        if (LEN == 1) begin
          state_next = DONE;
        end else if (accept) begin
          do_swap = 1'b1;
          if (i_ptr_reg == PTR_W'(1)) begin
            state_next = DONE;
          end else begin
            i_ptr_next = i_ptr_reg - 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      i_ptr_reg <= PTR_W'(LEN - 1);
    end else begin
      state_reg <= state_next;
      i_ptr_reg <= i_ptr_next;
    end
  end

  // Each cell swaps with the partner chosen this step; a j == i_ptr swap leaves it unchanged.
  for (genvar gi = 0; gi < LEN; gi++) begin : g_entry
    logic [LEN-1:0] cell_reg;
    logic [LEN-1:0] cell_next;

    always_comb begin
      cell_next = cell_reg;
      if (do_swap) begin
        if (PTR_W'(gi) == i_ptr_reg) begin
          cell_next = j_val;
        end else if (16'(gi) == cand) begin
          cell_next = ip_val;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        cell_reg <= LEN'(1) << gi;
      end else begin
        cell_reg <= cell_next;
      end
    end

    assign entry[gi] = cell_reg;
  end

  // Only a clean single-entry request in IDLE returns data; the home bit and
  // anything malformed read back as zero.
  always_comb begin
    rowbias_next = '0;
    if ((state_reg == IDLE) && $onehot(rqindex) && !rqindex[LEN]) begin
      for (int k = 0; k < LEN; k++) begin
        if (rqindex[k]) begin
          rowbias_next = rowbias_next | entry[k];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rowbias_reg <= '0;
    end else begin
      rowbias_reg <= rowbias_next;
    end
  end

  assign rowbias = rowbias_reg;
  assign ready   = (state_reg == IDLE);

endmodule

// File: tb/tb_row_bias_server.sv
// Scoreboard bench for row_bias_server: reads, illegal requests, seeded shuffles
// checked against an independent Fisher-Yates/LFSR model, and reset mid-shuffle.
module tb_row_bias_server;

  localparam int LEN = 9;

  logic           clock;
  logic           reset;
  logic [LEN:0]   rqindex;
  logic           updaterowbias;
  logic [15:0]    seed;
  logic           seedload;
  logic [LEN-1:0] rowbias;
  logic           ready;

  int checks = 0;
  int errors = 0;

  logic [LEN-1:0] model_perm [LEN];
  logic [LEN-1:0] exp_q [$];

  row_bias_server #(
    .LEN(LEN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rqindex      (rqindex),
    .updaterowbias(updaterowbias),
    .seed         (seed),
    .seedload     (seedload),
    .rowbias      (rowbias),
    .ready        (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int bits_for(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  task automatic model_identity();
    for (int i = 0; i < LEN; i++) begin
      model_perm[i] = '0;
      model_perm[i][i] = 1'b1;
    end
  endtask

  // Independent shuffle model; cyc returns the number of SHUFFLE cycles.
  task automatic model_shuffle(input logic [15:0] start, output int cyc);
    logic [15:0]    l;
    logic [LEN-1:0] t;
    int i;
    int j;
    l = start;
    i = LEN - 1;
    cyc = 0;
    while (cyc < 4000) begin
      j = int'(l & 16'((1 << bits_for(i + 1)) - 1));
      cyc = cyc + 1;
      if (j <= i) begin
        t = model_perm[i];
        model_perm[i] = model_perm[j];
        model_perm[j] = t;
        if (i == 1) break;
        i = i - 1;
      end
      l = lfsr_adv(l);
    end
  endtask

  task automatic issue(input logic [LEN:0] rq, input logic [LEN-1:0] expv,
                       input string name, output logic [LEN-1:0] got);
    logic [LEN-1:0] e;
    rqindex = rq;
    exp_q.push_back(expv);
    @(posedge clock);
    #1;
    rqindex = '0;
    e = exp_q.pop_front();
    got = rowbias;
    checks++;
    if (rowbias !== e) begin
      errors++;
      $display("FAIL %s rq=%b rowbias=%b expected=%b", name, rq, rowbias, e);
    end else begin
      $display("ok   %s rq=%b rowbias=%b", name, rq, rowbias);
    end
  endtask

  task automatic read_check(input string name);
    logic [LEN:0]   rq;
    logic [LEN-1:0] got;
    logic [LEN-1:0] or_all;
    or_all = '0;
    for (int k = 0; k < LEN; k++) begin
      rq = '0;
      rq[k] = 1'b1;
      issue(rq, model_perm[k], name, got);
      or_all = or_all | got;
      checks++;
      if ($countones(got) != 1) begin
        errors++;
        $display("FAIL %s_popcount entry=%0d value=%b required one bit set", name, k, got);
      end
    end
    checks++;
    if (or_all !== {LEN{1'b1}}) begin
      errors++;
      $display("FAIL %s_or_all got=%b expected=%b", name, or_all, {LEN{1'b1}});
    end
  endtask

  task automatic wait_ready(input int start, output int cnt);
    bit seen;
    cnt = start;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clock);
      #1;
      if (ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cnt++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_ready timeout ready=%b expected=1", ready);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    rqindex = '0;
    updaterowbias = 1'b0;
    seedload = 1'b0;
    seed = '0;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_identity();
  endtask

  task automatic check_busy_len(input string name, input int cnt, input int cyc);
    checks++;
    if (cnt != cyc + 1) begin
      errors++;
      $display("FAIL %s busy_cycles got=%0d expected=%0d", name, cnt, cyc + 1);
    end else begin
      $display("ok   %s busy_cycles=%0d", name, cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b expected=1", ready);
    end
    checks++;
    if (rowbias !== '0) begin
      errors++;
      $display("FAIL reset_rowbias got=%b expected=0", rowbias);
    end
    reset = 1'b0;
    model_identity();
    $display("ok   reset ready=%b rowbias=%b", ready, rowbias);
  endtask

  task automatic test_reads();
    logic [LEN-1:0] got;
    logic [LEN:0]   rq;
    apply_reset();
    read_check("identity_read");
    rq = '0;
    rq[LEN] = 1'b1;
    issue(rq, '0, "home_bit", got);
    issue(10'b0000000011, '0, "two_hot", got);
    issue(10'b0000000000, '0, "zero_rq", got);
    read_check("identity_after_illegal");
  endtask

  task automatic test_shuffle_seed();
    int cyc;
    int cnt;
    for (int rep = 0; rep < 2; rep++) begin
      apply_reset();
      seed = 16'h1234;
      seedload = 1'b1;
      @(posedge clock);
      #1;
      seedload = 1'b0;
      updaterowbias = 1'b1;
      model_shuffle(lfsr_adv(16'h1234), cyc);
      @(posedge clock);
      #1;
      updaterowbias = 1'b0;
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL shuffle1234_ready_drop got=%b expected=0", ready);
      end
      wait_ready(1, cnt);
      check_busy_len("shuffle1234", cnt, cyc);
      read_check("shuffle1234");
    end
  endtask

  task automatic test_seed_zero();
    int cyc;
    int cnt;
    apply_reset();
    seed = 16'h0000;
    seedload = 1'b1;
    updaterowbias = 1'b1;
    model_shuffle(16'hACE1, cyc);
    @(posedge clock);
    #1;
    seedload = 1'b0;
    updaterowbias = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL seed0_ready_drop got=%b expected=0", ready);
    end
    wait_ready(1, cnt);
    check_busy_len("seed0", cnt, cyc);
    read_check("seed0");
  endtask

  task automatic test_during_shuffle();
    int cyc;
    int cnt;
    logic [LEN-1:0] got;
    logic [LEN:0]   rq;
    apply_reset();
    seed = 16'h5A5A;
    seedload = 1'b1;
    updaterowbias = 1'b1;
    model_shuffle(16'h5A5A, cyc);
    @(posedge clock);
    #1;
    seedload = 1'b0;
    updaterowbias = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready_drop got=%b expected=0", ready);
    end
    // Read, re-trigger and re-seed while busy: all of it must be ignored.
    updaterowbias = 1'b1;
    seedload = 1'b1;
    seed = 16'hFFFF;
    rq = '0;
    rq[3] = 1'b1;
    issue(rq, '0, "read_in_shuffle", got);
    updaterowbias = 1'b0;
    seedload = 1'b0;
    if (ready === 1'b0) begin
      wait_ready(2, cnt);
    end else begin
      cnt = 1;
    end
    check_busy_len("busy_retrigger", cnt, cyc);
    read_check("busy_retrigger");
  endtask

  task automatic test_reset_mid();
    seed = 16'h1234;
    seedload = 1'b1;
    updaterowbias = 1'b1;
    @(posedge clock);
    #1;
    seedload = 1'b0;
    updaterowbias = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_identity();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready got=%b expected=1", ready);
    end else begin
      $display("ok   reset_mid ready=%b", ready);
    end
    read_check("reset_mid_identity");
  endtask

  initial begin
    reset = 1'b1;
    rqindex = '0;
    updaterowbias = 1'b0;
    seed = '0;
    seedload = 1'b0;
    test_reset();
    test_reads();
    test_shuffle_seed();
    test_seed_zero();
    test_during_shuffle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
